axi_vec_bridge: RTL and testbench
=================================

AXI_VEC_BRIDGE -- requirements
Module: axi_vec_bridge

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 11: element address width of the lane memories.
REQ-002 SHALL have parameter NUMLANES, default 8: lanes per beat; power of two.
REQ-003 SHALL have parameter WIDTH, default 16: bits per lane element; multiple of 8.
REQ-004 SHALL have parameter AXI_AW, default 32: AXI byte-address width.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk (input, 1, clock), reset (input, 1, async active-high reset).
REQ-006 SHALL have AXI4-Lite write ports: s_awaddr (in, AXI_AW), s_awvalid (in, 1), s_awready (out, 1), s_wdata (in, NUMLANES*WIDTH), s_wvalid (in, 1), s_wready (out, 1), s_bresp (out, 2), s_bvalid (out, 1), s_bready (in, 1).
REQ-007 SHALL have AXI4-Lite read ports: s_araddr (in, AXI_AW), s_arvalid (in, 1), s_arready (out, 1), s_rdata (out, NUMLANES*WIDTH), s_rresp (out, 2), s_rvalid (out, 1), s_rready (in, 1).
REQ-008 SHALL have downstream request ports feeding the lane-memory mux: axi_addr (out, ADDRWIDTH, base element index), axi_data (out, NUMLANES*WIDTH), axi_req_en (out, 1), axi_req_type (out, 1, 1=write, 0=read), mem_readdata (in, NUMLANES*WIDTH, memory read data).

Function
REQ-009 SHALL run FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_WAIT, RD_RESP; one transaction in flight at a time.
REQ-010 SHALL define beat size B = NUMLANES*WIDTH/8 bytes; element index = byte address / (WIDTH/8).
REQ-011 SHALL flag an address as an error if it is misaligned (address mod B != 0) or if the element index is >= 2^ADDRWIDTH.
REQ-012 SHALL assert s_awready only in IDLE with AW not yet captured; assert s_wready only in IDLE with W not yet captured; AW and W may arrive in either order or in the same cycle.
REQ-013 SHALL assert s_arready only in IDLE with neither AW nor W captured.
REQ-014 SHALL arbitrate when IDLE has nothing captured and s_arvalid and (s_awvalid or s_wvalid) are both high: grant read if last_wr=1, else grant write; the ungranted ready stays low; last_wr updates on each completed grant.
REQ-015 SHALL, the cycle after both AW and W are captured, enter WR_REQ: axi_req_en=1 and axi_req_type=1 for exactly one cycle, axi_addr = element index, axi_data = captured wdata; then enter WR_RESP.
REQ-016 SHALL, the cycle after the AR handshake, enter RD_REQ: axi_req_en=1 and axi_req_type=0 for one cycle; enter RD_WAIT next and register mem_readdata at the end of that cycle (1-cycle memory latency); then enter RD_RESP.
REQ-017 SHALL give a latency from AR handshake to s_rvalid of 3 cycles, and from the final AW/W handshake to s_bvalid of 2 cycles.
REQ-018 SHALL, on an error address, skip the *_REQ state (no axi_req_en pulse), go to *_RESP the cycle after capture, and return resp=2'b10 with s_rdata=0; otherwise resp=2'b00.
REQ-019 SHALL hold s_bvalid/s_rvalid and their resp/data stable until the respective ready is high, then return to IDLE the next cycle and clear the capture flags.
REQ-020 SHALL drive axi_req_en=0 in all states other than WR_REQ/RD_REQ, and axi_addr/axi_data/axi_req_type from capture registers at all times.
REQ-021 SHALL ignore mem_readdata except in RD_WAIT.

Reset
REQ-022 SHALL, while reset is high (asynchronously), force state=IDLE, last_wr=1, capture flags=0, s_bvalid=s_rvalid=0, s_bresp=s_rresp=0, s_rdata=0, axi_req_en=0, axi_addr=0, axi_data=0, axi_req_type=0.
REQ-023 SHALL drop any partially captured or in-flight transaction on reset mid-operation, issue no further request pulse, and accept new traffic the first cycle after reset deasserts.

Verification
REQ-024 SHALL verify aligned write: awaddr=0x40, wdata=128'h0123...CDEF in the same cycle -> one-cycle axi_req_en=1, type=1, axi_addr=0x020, data matches; bvalid 2 cycles later, bresp=00.
REQ-025 SHALL verify aligned read: araddr=0x40, mem_readdata=0xAAAA... in RD_WAIT -> axi_req_en pulse with type=0, addr=0x020; rvalid 3 cycles after AR handshake, rdata=0xAAAA..., rresp=00.
REQ-026 SHALL verify an error address: awaddr=0x42 (misaligned) or araddr=0x1000 (index 0x800 out of range) -> no axi_req_en pulse; resp=10; rdata=0.
REQ-027 SHALL verify W arriving 3 cycles before AW -> a single request issued after the AW handshake with the earlier wdata; arready stays low meanwhile.
REQ-028 SHALL verify simultaneous arvalid and awvalid+wvalid after reset -> read served first, then write; a repeat collision serves read then write again.
REQ-029 SHALL verify reset asserted in RD_WAIT and in WR_RESP -> outputs immediately at their reset values, no response delivered, and a fresh read completes normally afterward.

Source files
------------

// File: rtl/axi_vec_bridge.sv
// AXI4-Lite slave that turns single-beat reads/writes into one-cycle vector
// requests toward the lane-memory mux. One transaction is in flight at a time.
module axi_vec_bridge #(
   parameter int ADDRWIDTH = 11,
   parameter int NUMLANES  = 8,
   parameter int WIDTH     = 16,
   parameter int AXI_AW    = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [AXI_AW-1:0]         s_awaddr,
   input  logic                      s_awvalid,
   output logic                      s_awready,
   input  logic [NUMLANES*WIDTH-1:0] s_wdata,
   input  logic                      s_wvalid,
   output logic                      s_wready,
   output logic [1:0]                s_bresp,
   output logic                      s_bvalid,
   input  logic                      s_bready,
   input  logic [AXI_AW-1:0]         s_araddr,
   input  logic                      s_arvalid,
   output logic                      s_arready,
   output logic [NUMLANES*WIDTH-1:0] s_rdata,
   output logic [1:0]                s_rresp,
   output logic                      s_rvalid,
   input  logic                      s_rready,
   output logic [ADDRWIDTH-1:0]      axi_addr,
   output logic [NUMLANES*WIDTH-1:0] axi_data,
   output logic                      axi_req_en,
   output logic                      axi_req_type,
   input  logic [NUMLANES*WIDTH-1:0] mem_readdata
);
   localparam int DW    = NUMLANES * WIDTH;
   localparam int BYTES = DW / 8;
   localparam int ESH   = $clog2(WIDTH / 8);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_WAIT, RD_RESP} state_e;

   state_e               state_q, state_d;
   logic                 last_wr_q, last_wr_d;
   logic                 aw_got_q, aw_got_d;
   logic                 w_got_q, w_got_d;
   logic                 err_q, err_d;
   logic                 type_q, type_d;
   logic [ADDRWIDTH-1:0] addr_q, addr_d;
   logic [DW-1:0]        wdata_q, wdata_d;
   logic [DW-1:0]        rdata_q, rdata_d;
   logic [1:0]           bresp_q, bresp_d;
   logic [1:0]           rresp_q, rresp_d;
   logic                 idle, collide, aw_hs, w_hs, ar_hs;

   function automatic logic [ADDRWIDTH-1:0] elem_idx(input logic [AXI_AW-1:0] a);
      return ADDRWIDTH'(a >> ESH);
   endfunction

   // Misaligned to a beat, or element index beyond the lane memory depth.
   function automatic logic addr_err(input logic [AXI_AW-1:0] a);
      return ((a & AXI_AW'(BYTES - 1)) != '0) || ((a >> (ESH + ADDRWIDTH)) != '0);
   endfunction

   assign idle      = (state_q == IDLE);
   assign collide   = idle && !aw_got_q && !w_got_q && s_arvalid && (s_awvalid || s_wvalid);
   assign s_awready = idle && !aw_got_q && !(collide && last_wr_q);
   assign s_wready  = idle && !w_got_q && !(collide && last_wr_q);
   assign s_arready = idle && !aw_got_q && !w_got_q && !(collide && !last_wr_q);

   assign aw_hs = s_awvalid && s_awready;
   assign w_hs  = s_wvalid && s_wready;
   assign ar_hs = s_arvalid && s_arready;

   always_comb begin
      state_d   = state_q;
      last_wr_d = last_wr_q;
      aw_got_d  = aw_got_q;
      w_got_d   = w_got_q;
      err_d     = err_q;
      type_d    = type_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      bresp_d   = bresp_q;
      rresp_d   = rresp_q;
      case (state_q)
         IDLE: begin
            if (ar_hs) begin
               addr_d    = elem_idx(s_araddr);
               err_d     = addr_err(s_araddr);
               type_d    = 1'b0;
               last_wr_d = 1'b0;
               if (err_d) begin
                  state_d = RD_RESP;
                  rresp_d = 2'b10;
                  rdata_d = '0;
               end else begin
                  state_d = RD_REQ;
               end
            end else begin
               if (aw_hs) begin
                  aw_got_d  = 1'b1;
                  addr_d    = elem_idx(s_awaddr);
                  err_d     = addr_err(s_awaddr);
                  type_d    = 1'b1;
                  last_wr_d = 1'b1;
               end
               if (w_hs) begin
                  w_got_d   = 1'b1;
                  wdata_d   = s_wdata;
                  type_d    = 1'b1;
                  last_wr_d = 1'b1;
               end
               // err_d holds the AW verdict whether AW landed now or earlier.
               if (aw_got_d && w_got_d) begin
                  if (err_d) begin
                     state_d = WR_RESP;
                     bresp_d = 2'b10;
                  end else begin
                     state_d = WR_REQ;
                  end
               end
            end
         end
         WR_REQ: begin
            state_d = WR_RESP;
            bresp_d = 2'b00;
         end
         WR_RESP: begin
            if (s_bready) begin
               state_d  = IDLE;
               aw_got_d = 1'b0;
               w_got_d  = 1'b0;
            end
         end
         RD_REQ: state_d = RD_WAIT;
         RD_WAIT: begin
            rdata_d = mem_readdata;
            rresp_d = 2'b00;
            state_d = RD_RESP;
         end
         RD_RESP: begin
            if (s_rready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         last_wr_q <= 1'b1;
         aw_got_q  <= 1'b0;
         w_got_q   <= 1'b0;
         err_q     <= 1'b0;
         type_q    <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         bresp_q   <= 2'b00;
         rresp_q   <= 2'b00;
      end else begin
         state_q   <= state_d;
         last_wr_q <= last_wr_d;
         aw_got_q  <= aw_got_d;
         w_got_q   <= w_got_d;
         err_q     <= err_d;
         type_q    <= type_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         bresp_q   <= bresp_d;
         rresp_q   <= rresp_d;
      end
   end

   assign s_bvalid     = (state_q == WR_RESP);
   assign s_rvalid     = (state_q == RD_RESP);
   assign s_bresp      = bresp_q;
   assign s_rresp      = rresp_q;
   assign s_rdata      = rdata_q;
   assign axi_req_en   = (state_q == WR_REQ) || (state_q == RD_REQ);
   assign axi_addr     = addr_q;
   assign axi_data     = wdata_q;
   assign axi_req_type = type_q;

endmodule

// File: tb/tb_axi_vec_bridge.sv
// Directed + randomized bench for axi_vec_bridge; expected values come from
// address rules and a sparse memory model kept here.
module tb_axi_vec_bridge;
   localparam int AW  = 11;
   localparam int NL  = 8;
   localparam int W   = 16;
   localparam int AAW = 32;
   localparam int DW  = NL * W;
   localparam int BY  = DW / 8;
   localparam int EB  = W / 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [AAW-1:0] s_awaddr, s_araddr;
   logic          s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic          s_arvalid, s_arready, s_rvalid, s_rready;
   logic [DW-1:0] s_wdata, s_rdata, axi_data, mem_readdata;
   logic [1:0]    s_bresp, s_rresp;
   logic [AW-1:0] axi_addr;
   logic          axi_req_en, axi_req_type;

   int n_assert = 0;
   int n_fail   = 0;
   logic [DW-1:0] mem [int];

   axi_vec_bridge #(.ADDRWIDTH(AW), .NUMLANES(NL), .WIDTH(W), .AXI_AW(AAW)) dut (
      .clk(clk), .reset(reset),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .axi_addr(axi_addr), .axi_data(axi_data), .axi_req_en(axi_req_en),
      .axi_req_type(axi_req_type), .mem_readdata(mem_readdata)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic is_err(input logic [31:0] a);
      return ((a % 32'(BY)) != 0) || ((a / 32'(EB)) >= 32'(1 << AW));
   endfunction

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_bvalid"}, DW'(s_bvalid), '0);
      chk({tag, "_rvalid"}, DW'(s_rvalid), '0);
      chk({tag, "_bresp"}, DW'(s_bresp), '0);
      chk({tag, "_rresp"}, DW'(s_rresp), '0);
      chk({tag, "_rdata"}, s_rdata, '0);
      chk({tag, "_req_en"}, DW'(axi_req_en), '0);
      chk({tag, "_addr"}, DW'(axi_addr), '0);
      chk({tag, "_data"}, axi_data, '0);
      chk({tag, "_type"}, DW'(axi_req_type), '0);
   endtask

   task automatic issue_write(input logic [31:0] a, input logic [DW-1:0] d);
      s_awaddr = a; s_awvalid = 1'b1; s_wdata = d; s_wvalid = 1'b1; s_bready = 1'b0;
      #1;
      chk("wr_awready", DW'(s_awready), DW'(1));
      chk("wr_wready", DW'(s_wready), DW'(1));
      tick();
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_awaddr = $urandom; s_wdata = rnd_data();
   endtask

   // Entered one cycle after the final AW/W handshake edge.
   task automatic finish_write(input logic [31:0] a, input logic [DW-1:0] d, input int hold);
      logic e;
      e = is_err(a);
      #1;
      if (!e) begin
         chk("wr_req_en", DW'(axi_req_en), DW'(1));
         chk("wr_req_type", DW'(axi_req_type), DW'(1));
         chk("wr_req_addr", DW'(axi_addr), DW'(a / 32'(EB)));
         chk("wr_req_data", axi_data, d);
         chk("wr_early_bvalid", DW'(s_bvalid), '0);
         mem[int'(a / 32'(EB))] = d;
         tick();
      end
      for (int i = 0; i <= hold; i++) begin
         chk("wr_no_req", DW'(axi_req_en), '0);
         chk("wr_bvalid", DW'(s_bvalid), DW'(1));
         chk("wr_bresp", DW'(s_bresp), e ? DW'(2) : '0);
         if (i == hold) s_bready = 1'b1;
         tick();
      end
      s_bready = 1'b0;
      chk("wr_bvalid_clear", DW'(s_bvalid), '0);
   endtask

   task automatic issue_read(input logic [31:0] a);
      s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b0; mem_readdata = rnd_data();
      #1;
      chk("rd_arready", DW'(s_arready), DW'(1));
      tick();
      s_arvalid = 1'b0; s_araddr = $urandom;
   endtask

   // Entered one cycle after the AR handshake edge; memory data is only
   // meaningful during the RD_WAIT cycle, junk elsewhere.
   task automatic finish_read(input logic [31:0] a, input int hold);
      logic e;
      logic [DW-1:0] exp;
      int idx;
      e = is_err(a);
      idx = int'(a / 32'(EB));
      exp = '0;
      #1;
      if (!e) begin
         chk("rd_req_en", DW'(axi_req_en), DW'(1));
         chk("rd_req_type", DW'(axi_req_type), '0);
         chk("rd_req_addr", DW'(axi_addr), DW'(idx));
         chk("rd_early_rvalid", DW'(s_rvalid), '0);
         mem_readdata = rnd_data();
         tick();
         chk("rd_wait_no_req", DW'(axi_req_en), '0);
         chk("rd_wait_rvalid", DW'(s_rvalid), '0);
         if (!mem.exists(idx)) mem[idx] = rnd_data();
         exp = mem[idx];
         mem_readdata = exp;
         tick();
         mem_readdata = rnd_data();
      end
      for (int i = 0; i <= hold; i++) begin
         chk("rd_no_req", DW'(axi_req_en), '0);
         chk("rd_rvalid", DW'(s_rvalid), DW'(1));
         chk("rd_rresp", DW'(s_rresp), e ? DW'(2) : '0);
         chk("rd_rdata", s_rdata, exp);
         if (i == hold) s_rready = 1'b1;
         tick();
      end
      s_rready = 1'b0;
      chk("rd_rvalid_clear", DW'(s_rvalid), '0);
   endtask

   task automatic collide(input logic [31:0] ra, input logic [31:0] wa, input logic rd_first);
      logic [DW-1:0] d;
      d = rnd_data();
      s_araddr = ra; s_arvalid = 1'b1; s_rready = 1'b0;
      s_awaddr = wa; s_awvalid = 1'b1; s_wdata = d; s_wvalid = 1'b1; s_bready = 1'b0;
      mem_readdata = rnd_data();
      #1;
      chk("arb_arready", DW'(s_arready), DW'(rd_first));
      chk("arb_awready", DW'(s_awready), DW'(!rd_first));
      chk("arb_wready", DW'(s_wready), DW'(!rd_first));
      tick();
      if (rd_first) begin
         s_arvalid = 1'b0;
         finish_read(ra, 0);
         #1;
         chk("arb_second_awready", DW'(s_awready), DW'(1));
         tick();
         s_awvalid = 1'b0; s_wvalid = 1'b0; s_wdata = rnd_data();
         finish_write(wa, d, 0);
      end else begin
         s_awvalid = 1'b0; s_wvalid = 1'b0; s_wdata = rnd_data();
         finish_write(wa, d, 0);
         #1;
         chk("arb_second_arready", DW'(s_arready), DW'(1));
         tick();
         s_arvalid = 1'b0;
         finish_read(ra, 0);
      end
   endtask

   initial begin
      logic [DW-1:0] d0;
      logic [31:0]   a;
      reset = 1'b0;
      s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wvalid = 1'b0; s_bready = 1'b0;
      s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0; mem_readdata = '0;
      #1 reset = 1'b1;
      #2;
      chk_reset_vals("reset");
      tick();
      reset = 1'b0;

      // Aligned write, AW and W together.
      d0 = 128'h0123456789ABCDEF0123456789ABCDEF;
      issue_write(32'h40, d0);
      finish_write(32'h40, d0, 0);

      // Aligned read returning the lane-memory pattern.
      mem[32'h20] = {8{16'hAAAA}};
      issue_read(32'h40);
      finish_read(32'h40, 1);

      // Error addresses: misaligned write, out-of-range read.
      d0 = rnd_data();
      issue_write(32'h42, d0);
      finish_write(32'h42, d0, 1);
      issue_read(32'h1000);
      finish_read(32'h1000, 0);

      // W three cycles ahead of AW, with a read pending meanwhile.
      d0 = rnd_data();
      s_wdata = d0; s_wvalid = 1'b1;
      #1;
      chk("wlead_wready", DW'(s_wready), DW'(1));
      tick();
      s_wvalid = 1'b0; s_wdata = rnd_data(); s_araddr = 32'h80; s_arvalid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("wlead_arready", DW'(s_arready), '0);
         chk("wlead_no_req", DW'(axi_req_en), '0);
         chk("wlead_wready_low", DW'(s_wready), '0);
         tick();
      end
      s_awaddr = 32'h60; s_awvalid = 1'b1;
      #1;
      chk("wlead_arready_aw", DW'(s_arready), '0);
      chk("wlead_awready", DW'(s_awready), DW'(1));
      tick();
      s_awvalid = 1'b0; s_arvalid = 1'b0;
      finish_write(32'h60, d0, 1);

      // Read/write collisions right after reset, then alternating priority.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      collide(32'h80, 32'hC0, 1'b1);
      collide(32'h100, 32'h140, 1'b1);
      issue_read(32'h180);
      finish_read(32'h180, 0);
      collide(32'h1C0, 32'h200, 1'b0);

      // Reset while waiting on memory data.
      issue_read(32'h240);
      tick();
      mem_readdata = rnd_data();
      reset = 1'b1;
      #1;
      chk_reset_vals("rst_rdwait");
      tick();
      reset = 1'b0;
      chk("rst_rdwait_no_rvalid", DW'(s_rvalid), '0);
      issue_read(32'h240);
      finish_read(32'h240, 0);

      // Reset while an error write response is pending.
      d0 = rnd_data();
      issue_write(32'h1002, d0);
      #1;
      chk("rst_wr_pre_bvalid", DW'(s_bvalid), DW'(1));
      reset = 1'b1;
      #1;
      chk_reset_vals("rst_wrresp");
      tick();
      reset = 1'b0;
      chk("rst_wrresp_no_bvalid", DW'(s_bvalid), '0);
      issue_read(32'h40);
      finish_read(32'h40, 0);

      // Random traffic over a region that straddles the top of the memory.
      for (int n = 0; n < 40; n++) begin
         a = 32'($urandom_range(0, 299)) * 32'd16;
         if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 15));
         if ($urandom_range(0, 1) == 1) begin
            d0 = rnd_data();
            issue_write(a, d0);
            finish_write(a, d0, int'($urandom_range(0, 2)));
         end else begin
            issue_read(a);
            finish_read(a, int'($urandom_range(0, 2)));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
